// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling 8N1/8E1 serial receiver. Recovers frames from
//               rx_pin, samples each bit at its middle and reports every
//               completed frame with a one-cycle strobe and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       baud_tick_os,
   input  logic       rx_pin,
   input  logic       parity_enable,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       parity_error,
   output logic       framing_error
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] MID_START = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] MID_BIT   = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   logic          sync_ff1;
   logic          rx_sync;
   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_nxt;
   logic [7:0]    shift_reg;
   logic [7:0]    shift_nxt;
   logic          par_en;
   logic          par_en_nxt;
   logic          par_err_pend;
   logic          par_err_pend_nxt;
   logic          frame_done;
   logic          frame_ferr;

   // Two-flop synchronizer for the asynchronous line; idles high after reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_ff1 <= 1'b1;
         rx_sync  <= 1'b1;
      end else begin
         sync_ff1 <= rx_pin;
         rx_sync  <= sync_ff1;
      end
   end

   // Frame state register, sample datapath and registered frame report
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shift_reg     <= '0;
         par_en        <= 1'b0;
         par_err_pend  <= 1'b0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         bit_idx      <= bit_idx_nxt;
         shift_reg    <= shift_nxt;
         par_en       <= par_en_nxt;
         par_err_pend <= par_err_pend_nxt;
         rx_valid     <= frame_done;
         if (frame_done) begin
            rx_data       <= shift_nxt;
            parity_error  <= par_en & par_err_pend;
            framing_error <= frame_ferr;
         end
      end
   end

   // Next-state logic: every decision is taken on a baud tick at mid-bit
   always_comb begin
      state_nxt        = state;
      cnt_nxt          = cnt;
      bit_idx_nxt      = bit_idx;
      shift_nxt        = shift_reg;
      par_en_nxt       = par_en;
      par_err_pend_nxt = par_err_pend;
      frame_done       = 1'b0;
      frame_ferr       = 1'b0;
      if (baud_tick_os) begin
         case (state)
            S_IDLE: begin
               cnt_nxt = '0;
               if (!rx_sync) begin
                  state_nxt = S_START;
               end
            end
            S_START: begin
               if (cnt == MID_START) begin
                  cnt_nxt = '0;
                  if (rx_sync) begin
                     // Line went back high before mid start bit: glitch
                     state_nxt = S_IDLE;
                  end else begin
                     state_nxt        = S_DATA;
                     bit_idx_nxt      = '0;
                     par_en_nxt       = parity_enable;
                     par_err_pend_nxt = 1'b0;
                  end
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            S_DATA: begin
               // Counter wraps to zero exactly at each mid-bit sample
               cnt_nxt = cnt + CW'(1);
               if (cnt == MID_BIT) begin
                  shift_nxt[bit_idx] = rx_sync;
                  bit_idx_nxt        = bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state_nxt = par_en ? S_PARITY : S_STOP;
                  end
               end
            end
            S_PARITY: begin
               cnt_nxt = cnt + CW'(1);
               if (cnt == MID_BIT) begin
                  // Even parity: received bit must equal XOR of the data
                  par_err_pend_nxt = rx_sync ^ (^shift_reg);
                  state_nxt        = S_STOP;
               end
            end
            S_STOP: begin
               cnt_nxt = cnt + CW'(1);
               if (cnt == MID_BIT) begin
                  frame_done = 1'b1;
                  frame_ferr = ~rx_sync;
                  state_nxt  = rx_sync ? S_IDLE : S_WAIT_IDLE;
               end
            end
            S_WAIT_IDLE: begin
               // A held-low break is reported once; wait for the line to recover
               cnt_nxt = '0;
               if (rx_sync) begin
                  state_nxt = S_IDLE;
               end
            end
            default: begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Busy covers the committed part of a frame only
   always_comb begin
      rx_busy = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. A serial driver issues frames
//               and queues the expected report; a monitor pops and compares on
//               every rx_valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       baud_tick_os = 1'b0;
   logic       rx_pin = 1'b1;
   logic       parity_enable = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       parity_error;
   logic       framing_error;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   busy_cnt = 0;
   int   valid_cnt = 0;
   int   tick_div = 2;
   int   tick_ctr = 0;

   uart_rx #(.OVERSAMPLE(OS)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .baud_tick_os  (baud_tick_os),
      .rx_pin        (rx_pin),
      .parity_enable (parity_enable),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_busy       (rx_busy),
      .parity_error  (parity_error),
      .framing_error (framing_error)
   );

   always #5 clk = ~clk;

   // Oversample tick: one clk wide, every tick_div clocks, changed on negedge
   always @(negedge clk) begin
      if (tick_ctr >= tick_div - 1) begin
         tick_ctr     = 0;
         baud_tick_os = 1'b1;
      end else begin
         tick_ctr     = tick_ctr + 1;
         baud_tick_os = 1'b0;
      end
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rx_busy) busy_cnt++;
         if (rx_valid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got data %0h expected no strobe", rx_data);
            end else begin
               e = sb.pop_front();
               check("rx_data", int'(rx_data), int'(e.d));
               check("parity_error", int'(parity_error), int'(e.pe));
               check("framing_error", int'(framing_error), int'(e.fe));
               check("busy_at_valid", int'(rx_busy), 0);
            end
         end
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         do @(posedge clk); while (baud_tick_os !== 1'b1);
      end
      @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rx_pin = b;
      wait_ticks(OS);
   endtask

   // Reference: even parity bit is XOR of data; mismatch only counts with parity on
   task automatic send_frame(input logic [7:0] d, input logic pe, input logic bad_par,
                             input logic stop_b, input int idle_bits);
      exp_t e;
      logic pbit;
      pbit = (^d) ^ bad_par;
      e.d  = d;
      e.pe = pe && (pbit != (^d));
      e.fe = !stop_b;
      sb.push_back(e);
      parity_enable = pe;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (pe) send_bit(pbit);
      send_bit(stop_b);
      for (int i = 0; i < idle_bits; i++) send_bit(1'b1);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check(name, sb.size(), 0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_data"}, int'(rx_data), 0);
      check({name, "_valid"}, int'(rx_valid), 0);
      check({name, "_busy"}, int'(rx_busy), 0);
      check({name, "_perr"}, int'(parity_error), 0);
      check({name, "_ferr"}, int'(framing_error), 0);
   endtask

   initial begin
      int snap_busy;
      int snap_valid;
      fork
         monitor();
         begin
            #3_000_000;
            $display("FAIL watchdog: simulation time limit reached with %0d expected frames pending", sb.size());
            $fatal(1);
         end
      join_none

      // Reset values
      repeat (5) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      wait_ticks(20);

      // 8E1 0x55, busy must have been seen and fall by the strobe
      snap_busy = busy_cnt;
      send_frame(8'h55, 1'b1, 1'b0, 1'b1, 2);
      drain("drain_55");
      checks++;
      if (busy_cnt == snap_busy) begin
         errors++;
         $display("FAIL busy_seen_55: got no busy cycles expected some");
      end

      // 8N1 back-to-back
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0);
      send_frame(8'h01, 1'b0, 1'b0, 1'b1, 2);
      drain("drain_b2b");

      // Glitch of 3 ticks: no busy, no strobe
      snap_busy  = busy_cnt;
      snap_valid = valid_cnt;
      rx_pin = 1'b0;
      wait_ticks(3);
      rx_pin = 1'b1;
      wait_ticks(3 * OS);
      check("glitch_busy_cycles", busy_cnt - snap_busy, 0);
      check("glitch_valid_count", valid_cnt - snap_valid, 0);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1);
      drain("drain_after_glitch");

      // Break: 0x3C with low stop, line held low 30 bit times
      snap_valid = valid_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
      rx_pin = 1'b0;
      wait_ticks(30 * OS);
      check("break_valid_count", valid_cnt - snap_valid, 1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1);
      drain("drain_break");

      // 8E1 0x01 with wrong parity bit (0)
      send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1);
      drain("drain_parity");

      // Reset after data bit 4 aborts the frame
      snap_valid = valid_cnt;
      parity_enable = 1'b0;
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(i[0]);
      reset_n = 1'b0;
      rx_pin  = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("midframe_reset");
      reset_n = 1'b1;
      wait_ticks(2 * OS);
      check("abort_valid_count", valid_cnt - snap_valid, 0);
      send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1);
      drain("drain_7e");

      // Randomized frames, tick spacing and error injection
      for (int n = 0; n < 40; n++) begin
         logic [7:0] d;
         logic pe, bad, stopb;
         int idle;
         tick_div = 1 + int'($urandom_range(2));
         d     = 8'($urandom);
         pe    = 1'($urandom);
         bad   = ($urandom_range(3) == 0);
         stopb = ($urandom_range(4) != 0);
         idle  = stopb ? int'($urandom_range(2)) : 1 + int'($urandom_range(1));
         send_frame(d, pe, bad, stopb, idle);
      end
      drain("drain_random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receiver that consumes the line driven by `uart_tx`: it recovers 8N1/8E1 frames from `rx_pin` and presents each received byte on a parallel bus with a one-cycle valid strobe and per-frame error flags. It runs from the same system clock as `uart_tx`, but its enable tick comes from a baud generator running at OVERSAMPLE × baud rate. It sits between the pad/loopback of `tx_pin` and the byte-consuming logic (RX FIFO or command decoder).

## Interface
- `OVERSAMPLE`, 16: ticks per bit; power of two, ≥ 4.
- `clk`  in  1  system clock; all logic on posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `baud_tick_os`  in  1  one-`clk` pulse at OVERSAMPLE × baud rate.
- `rx_pin`  in  1  asynchronous serial input; idles high.
- `parity_enable`  in  1  1 = 8E1 frames (even parity, the same convention as `uart_tx`); 0 = 8N1.
- `rx_data`  out  8  last received byte, LSB first on the line.
- `rx_valid`  out  1  one-`clk` pulse per completed frame.
- `rx_busy`  out  1  high from start-bit acceptance until the frame ends.
- `parity_error`  out  1  parity mismatch in the frame flagged by `rx_valid`.
- `framing_error`  out  1  stop bit sampled low in the frame flagged by `rx_valid`.

## Operation
- `rx_pin` passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value.
- Sample counter `cnt` is $clog2(OVERSAMPLE) bits and advances only on `baud_tick_os`. Bit index is 3 bits.
- States:
  - IDLE → START on a tick with the line low; `cnt` = 0.
  - START: at `cnt` == OVERSAMPLE/2−1 (mid start bit):
    - line high → false start; go to IDLE with no output.
    - line low → go to DATA, `cnt` = 0, bit index = 0.
    - `parity_enable` is latched here for the whole frame.
  - DATA: at `cnt` == OVERSAMPLE−1 (mid bit):
    - shift the line into bit[index]; index increments.
    - after index 7, go to PARITY if the latched enable is 1, else to STOP.
  - PARITY: at mid bit, the received bit is compared with XOR of the 8 data bits; mismatch → pending parity error.
  - STOP: at mid bit:
    - line high → complete the frame, go to IDLE.
    - line low → complete the frame with `framing_error`, go to WAIT_IDLE.
  - WAIT_IDLE: stay until a tick sees the line high, then go to IDLE. A held-low break therefore produces exactly one frame report.
- On frame completion, in the same update:
  - `rx_data`, `parity_error` and `framing_error` are loaded.
  - `rx_valid` pulses.
  - these three outputs hold until the next completion.
- Frames with errors are still reported with `rx_valid`, and `rx_data` carries the bits received.
- `rx_busy` is high in DATA, PARITY and STOP. It is low in IDLE, START and WAIT_IDLE.
- `baud_tick_os` low: all state holds; there is no timeout.

## Timing
- Reset (`reset_n` low at a posedge) sets:
  - state IDLE, `cnt` 0, synchronizer 1s.
  - outputs: `rx_data` 0x00, `rx_valid` 0, `rx_busy` 0, `parity_error` 0, `framing_error` 0.
- Reset mid-frame aborts the frame with no `rx_valid`. Reception resumes with the next falling edge after reset is released.
- Input latency: 2 `clk` through the synchronizer before the edge is visible to the state machine.
- `rx_valid` is registered and is high for exactly the one `clk` following the tick that samples the stop-bit middle.
- Timing from the start-bit falling edge to `rx_valid`, at ±1 tick synchronizer/tick-phase skew:
  - 8N1: 9.5 bit periods.
  - 8E1: 10.5 bit periods.
- Sampling point is mid-bit. Tolerated baud mismatch is ≥ ±3% at OVERSAMPLE = 16.
- Back-to-back frames: a new start bit can be detected on the first tick after returning to IDLE, so no idle gap beyond the stop bit is required.
- Ticks spaced one `clk` apart (continuous `baud_tick_os`) are legal.

## Test plan
- Loop back `uart_tx` → `uart_rx`, `parity_enable` = 1, send 0x55:
  - `rx_valid` pulses once; `rx_data` = 0x55.
  - both error flags 0; `rx_busy` falls on the stop bit.
- `parity_enable` = 0, send 0xA5 then 0x01 back-to-back: two `rx_valid` pulses, with `rx_data` 0xA5 then 0x01, no errors.
- Drive 8E1 frame 0x01 with parity bit 0 (wrong): `rx_valid` with `rx_data` = 0x01, `parity_error` = 1, `framing_error` = 0.
- Drive 0x3C with stop bit low, then hold the line low for 30 bit times (break):
  - exactly one `rx_valid`, with `framing_error` = 1.
  - no further pulse until the line returns high and a new frame is sent; that frame then decodes with flags cleared.
- Glitch: pull the line low for 3 ticks only → no `rx_busy`, no `rx_valid`, state back in IDLE.
- Assert `reset_n` low after data bit 4 of a frame → outputs at reset values, no `rx_valid`. The next full frame 0x7E is received correctly.
